// File: rtl/knn_vote_if.sv
// Sorted-array input and vote-result output bundle for knn_vote.
interface knn_vote_if #(
    parameter int unsigned L      = 3,
    parameter int unsigned W      = 16,
    parameter int unsigned TYPE_W = 3,
    parameter int unsigned K      = 5
);
    localparam int unsigned N_ELEM = 1 << L;
    localparam int unsigned VOTE_W = $clog2(K + 1);

    logic                       in_valid;
    logic                       in_ready;
    logic [W*N_ELEM-1:0]        in;
    logic [TYPE_W*N_ELEM-1:0]   in_type;
    logic                       out_valid;
    logic [TYPE_W-1:0]          out_class;
    logic [VOTE_W-1:0]          out_votes;

    modport master (
        output in_valid, in, in_type,
        input  in_ready, out_valid, out_class, out_votes
    );

    modport slave (
        input  in_valid, in, in_type,
        output in_ready, out_valid, out_class, out_votes
    );
endinterface

// File: rtl/knn_vote.sv
// Majority vote over the K nearest entries of a sorted distance/type array.
// Sequential: K tally cycles, N_CLASS argmax cycles, one result cycle.
module knn_vote #(
    parameter int unsigned L      = 3,
    parameter int unsigned W      = 16,
    parameter int unsigned TYPE_W = 3,
    parameter int unsigned K      = 5
) (
    input  logic       clk,
    input  logic       rst,
    knn_vote_if.slave  bus
);
    localparam int unsigned N_ELEM  = 1 << L;
    localparam int unsigned N_CLASS = 1 << TYPE_W;
    localparam int unsigned VOTE_W  = $clog2(K + 1);

    if (K < 1 || K > N_ELEM) begin : g_bad_k
        $error("knn_vote: K must be in 1..N_ELEM");
    end

    typedef enum logic [1:0] {IDLE, COUNT, ARGMAX, DONE} state_t;

    state_t              r_state;
    state_t              w_next_state;
    logic [W-1:0]        r_dist [N_ELEM];
    logic [TYPE_W-1:0]   r_type [N_ELEM];
    logic [VOTE_W-1:0]   r_cnt  [N_CLASS];
    logic [L-1:0]        r_idx;
    logic [TYPE_W-1:0]   r_cls;
    logic [TYPE_W-1:0]   r_best_cls;
    logic [VOTE_W-1:0]   r_best_cnt;
    logic                r_in_ready;
    logic                r_out_valid;
    logic [TYPE_W-1:0]   r_out_class;
    logic [VOTE_W-1:0]   r_out_votes;

    logic                w_accept;
    logic                w_last_idx;
    logic                w_last_cls;
    logic                w_vote;
    logic [TYPE_W-1:0]   w_cur_type;
    logic [TYPE_W-1:0]   w_best_cls;
    logic [VOTE_W-1:0]   w_best_cnt;

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_class = r_out_class;
    assign bus.out_votes = r_out_votes;

    // Next state plus the running argmax including the current class.
    always_comb begin
        w_next_state = r_state;
        w_accept     = bus.in_valid && r_in_ready;
        w_last_idx   = (r_idx == L'(K - 1));
        w_last_cls   = (r_cls == TYPE_W'(N_CLASS - 1));
        w_vote       = (r_dist[r_idx] != '1);
        w_cur_type   = r_type[r_idx];
        w_best_cls   = r_best_cls;
        w_best_cnt   = r_best_cnt;
        if (r_cnt[r_cls] > r_best_cnt) begin
            w_best_cls = r_cls;
            w_best_cnt = r_cnt[r_cls];
        end
        case (r_state)
            IDLE:    if (w_accept)   w_next_state = COUNT;
            COUNT:   if (w_last_idx) w_next_state = ARGMAX;
            ARGMAX:  if (w_last_cls) w_next_state = DONE;
            DONE:    w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    // Datapath: capture, tally, argmax scan and registered result.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < N_ELEM; i++) begin
                r_dist[L'(i)] <= '0;
                r_type[L'(i)] <= '0;
            end
            for (int unsigned c = 0; c < N_CLASS; c++) begin
                r_cnt[TYPE_W'(c)] <= '0;
            end
            r_idx       <= '0;
            r_cls       <= '0;
            r_best_cls  <= '0;
            r_best_cnt  <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out_class <= '0;
            r_out_votes <= '0;
        end else begin
            r_in_ready  <= (w_next_state == IDLE);
            r_out_valid <= (w_next_state == DONE);
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        for (int unsigned i = 0; i < N_ELEM; i++) begin
                            r_dist[L'(i)] <= bus.in[i*W +: W];
                            r_type[L'(i)] <= bus.in_type[i*TYPE_W +: TYPE_W];
                        end
                        for (int unsigned c = 0; c < N_CLASS; c++) begin
                            r_cnt[TYPE_W'(c)] <= '0;
                        end
                        r_idx <= '0;
                    end
                end
                COUNT: begin
                    // All-ones distance is padding and casts no vote.
                    if (w_vote) begin
                        r_cnt[w_cur_type] <= r_cnt[w_cur_type] + VOTE_W'(1);
                    end
                    r_idx <= r_idx + L'(1);
                    if (w_last_idx) begin
                        r_cls      <= '0;
                        r_best_cls <= '0;
                        r_best_cnt <= '0;
                    end
                end
                ARGMAX: begin
                    r_best_cls <= w_best_cls;
                    r_best_cnt <= w_best_cnt;
                    r_cls      <= r_cls + TYPE_W'(1);
                    if (w_last_cls) begin
                        r_out_class <= w_best_cls;
                        r_out_votes <= w_best_cnt;
                    end
                end
                DONE: begin
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_knn_vote.sv
// Scoreboard bench for knn_vote: a K=5 and a K=8 instance, two-bit class labels.
module tb_knn_vote;
    localparam int unsigned L  = 3;
    localparam int unsigned W  = 16;
    localparam int unsigned TW = 2;
    localparam int unsigned NC = 4;
    localparam int LAT5 = 5 + 4 + 1;
    localparam int LAT8 = 8 + 4 + 1;
    localparam int II5  = 5 + 4 + 2;

    typedef struct {
        logic [TW-1:0] cls;
        int            votes;
        int            acc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t q5[$];
    exp_t q8[$];

    knn_vote_if #(.L(L), .W(W), .TYPE_W(TW), .K(5)) ifc5();
    knn_vote_if #(.L(L), .W(W), .TYPE_W(TW), .K(8)) ifc8();

    knn_vote #(.L(L), .W(W), .TYPE_W(TW), .K(5)) dut5 (.clk(clk), .rst(rst), .bus(ifc5.slave));
    knn_vote #(.L(L), .W(W), .TYPE_W(TW), .K(8)) dut8 (.clk(clk), .rst(rst), .bus(ifc8.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic rd_ready(input int sel);
        return (sel == 8) ? ifc8.in_ready : ifc5.in_ready;
    endfunction

    function automatic logic rd_valid(input int sel);
        return (sel == 8) ? ifc8.out_valid : ifc5.out_valid;
    endfunction

    function automatic logic [TW-1:0] rd_class(input int sel);
        return (sel == 8) ? ifc8.out_class : ifc5.out_class;
    endfunction

    function automatic logic [31:0] rd_votes(input int sel);
        return (sel == 8) ? 32'(ifc8.out_votes) : 32'(ifc5.out_votes);
    endfunction

    task automatic drive(input int sel, input logic v, input logic [127:0] dv, input logic [15:0] tv);
        if (sel == 8) begin
            ifc8.in_valid = v; ifc8.in = dv; ifc8.in_type = tv;
        end else begin
            ifc5.in_valid = v; ifc5.in = dv; ifc5.in_type = tv;
        end
    endtask

    // Reference vote: count non-sentinel labels in the first k slots, lowest class wins ties.
    function automatic exp_t model(input logic [127:0] dv, input logic [15:0] tv, input int k, input int acc);
        int   tally [NC];
        exp_t e;
        for (int c = 0; c < int'(NC); c++) tally[c] = 0;
        for (int i = 0; i < k; i++) begin
            if (dv[i*16 +: 16] != 16'hFFFF) tally[int'(tv[i*2 +: 2])] += 1;
        end
        e.cls = '0; e.votes = 0; e.acc = acc;
        for (int c = 0; c < int'(NC); c++) begin
            if (tally[c] > e.votes) begin
                e.cls = TW'(c); e.votes = tally[c];
            end
        end
        return e;
    endfunction

    task automatic rand_arr(output logic [127:0] dv, output logic [15:0] tv);
        for (int i = 0; i < 8; i++) begin
            dv[i*16 +: 16] = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom_range(0, 16'hFFFE));
            tv[i*2 +: 2]   = 2'($urandom_range(0, 3));
        end
    endtask

    task automatic send(input int sel, input logic [127:0] dv, input logic [15:0] tv,
                        input logic [TW-1:0] ecls, input int evotes);
        exp_t e;
        int   i;
        i = 0;
        @(negedge clk);
        while (rd_ready(sel) !== 1'b1 && i < 40) begin
            @(negedge clk);
            i++;
        end
        n_cmp++;
        if (rd_ready(sel) !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready k=%0d: in_ready=%b required=1", sel, rd_ready(sel));
        end
        drive(sel, 1'b1, dv, tv);
        e.cls = ecls; e.votes = evotes; e.acc = cyc;
        if (sel == 8) q8.push_back(e); else q5.push_back(e);
        @(negedge clk);
        drive(sel, 1'b0, {$urandom, $urandom, $urandom, $urandom}, 16'($urandom));
    endtask

    task automatic wait_out(input int sel, input string name);
        exp_t e;
        bit   seen;
        int   lat;
        seen = 1'b0;
        lat  = (sel == 8) ? LAT8 : LAT5;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (rd_valid(sel) === 1'b1) begin
                seen = 1'b1;
                if ((sel == 8 && q8.size() == 0) || (sel != 8 && q5.size() == 0)) begin
                    n_cmp++; n_bad++;
                    $display("FAIL %s unexpected_out: out_valid=1 required=0 (nothing pending)", name);
                end else begin
                    e = (sel == 8) ? q8.pop_front() : q5.pop_front();
                    n_cmp++;
                    if (rd_class(sel) !== e.cls) begin
                        n_bad++;
                        $display("FAIL %s class: got %0d required %0d", name, rd_class(sel), e.cls);
                    end
                    n_cmp++;
                    if (rd_votes(sel) !== 32'(e.votes)) begin
                        n_bad++;
                        $display("FAIL %s votes: got %0d required %0d", name, rd_votes(sel), e.votes);
                    end
                    n_cmp++;
                    if (cyc - e.acc != lat) begin
                        n_bad++;
                        $display("FAIL %s latency: got %0d required %0d", name, cyc - e.acc, lat);
                    end
                end
            end
        end
        if (!seen) begin
            n_cmp++; n_bad++;
            $display("FAIL %s timeout: out_valid never 1 within 40 cycles", name);
        end
        @(negedge clk);
        n_cmp++;
        if (rd_valid(sel) !== 1'b0) begin
            n_bad++;
            $display("FAIL %s strobe_width: out_valid=%b required=0", name, rd_valid(sel));
        end
    endtask

    task automatic test_reset();
        drive(5, 1'b0, '0, '0);
        drive(8, 1'b0, '0, '0);
        #12;
        n_cmp++;
        if ({ifc5.in_ready, ifc5.out_valid, ifc5.out_class, ifc5.out_votes} !== {1'b1, 1'b0, 2'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL reset_k5: rdy=%b vld=%b cls=%0d votes=%0d required 1 0 0 0",
                     ifc5.in_ready, ifc5.out_valid, ifc5.out_class, ifc5.out_votes);
        end
        n_cmp++;
        if ({ifc8.in_ready, ifc8.out_valid, ifc8.out_class, ifc8.out_votes} !== {1'b1, 1'b0, 2'd0, 4'd0}) begin
            n_bad++;
            $display("FAIL reset_k8: rdy=%b vld=%b cls=%0d votes=%0d required 1 0 0 0",
                     ifc8.in_ready, ifc8.out_valid, ifc8.out_class, ifc8.out_votes);
        end
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_directed();
        // Types listed element 7 .. element 0; distances 1..8 unless noted.
        send(5, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1},
             {2'd0,2'd0,2'd0,2'd2,2'd3,2'd2,2'd1,2'd2}, 2'd2, 3);
        wait_out(5, "majority");
        send(5, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1},
             {2'd0,2'd0,2'd0,2'd0,2'd1,2'd3,2'd3,2'd1}, 2'd1, 2);
        wait_out(5, "tie_low");
        send(5, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1},
             {2'd1,2'd1,2'd1,2'd1,2'd0,2'd2,2'd1,2'd0}, 2'd0, 2);
        wait_out(5, "k_window");
        send(5, {16'd3,16'd2,16'd1,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF},
             {2'd3,2'd3,2'd3,2'd2,2'd2,2'd1,2'd1,2'd1}, 2'd0, 0);
        wait_out(5, "all_sentinel");
        send(5, {16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,16'd9,16'd4},
             {2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd3,2'd3}, 2'd3, 2);
        wait_out(5, "sentinel_skip");
    endtask

    task automatic test_back_to_back();
        logic [127:0] dv;
        logic [15:0]  tv;
        exp_t         e;
        int accepts, acc_prev, outs, low_cnt;
        accepts = 0; acc_prev = 0; outs = 0; low_cnt = 0;
        for (int c = 0; c < 60 && (accepts < 2 || q5.size() > 0); c++) begin
            @(negedge clk);
            if (ifc5.out_valid === 1'b1) begin
                outs++;
                if (q5.size() > 0) begin
                    e = q5.pop_front();
                    n_cmp++;
                    if (ifc5.out_class !== e.cls || 32'(ifc5.out_votes) !== 32'(e.votes)) begin
                        n_bad++;
                        $display("FAIL b2b_result: got cls=%0d votes=%0d required cls=%0d votes=%0d",
                                 ifc5.out_class, ifc5.out_votes, e.cls, e.votes);
                    end
                end
            end
            if (accepts < 2) begin
                rand_arr(dv, tv);
                drive(5, 1'b1, dv, tv);
                if (ifc5.in_ready === 1'b1) begin
                    if (accepts == 1) begin
                        n_cmp++;
                        if (cyc - acc_prev != II5) begin
                            n_bad++;
                            $display("FAIL b2b_interval: got %0d required %0d", cyc - acc_prev, II5);
                        end
                    end
                    q5.push_back(model(dv, tv, 5, cyc));
                    acc_prev = cyc;
                    accepts++;
                end else begin
                    low_cnt++;
                end
            end else begin
                drive(5, 1'b0, dv, tv);
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (ifc5.out_valid === 1'b1) outs++;
        end
        n_cmp++;
        if (outs != 2) begin
            n_bad++;
            $display("FAIL b2b_strobes: got %0d required 2", outs);
        end
        n_cmp++;
        if (low_cnt != II5 - 1) begin
            n_bad++;
            $display("FAIL b2b_ready_low: got %0d required %0d", low_cnt, II5 - 1);
        end
    endtask

    task automatic test_reset_mid_argmax();
        exp_t e;
        int   pulses;
        pulses = 0;
        send(5, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1},
             {2'd0,2'd0,2'd0,2'd1,2'd1,2'd1,2'd2,2'd2}, 2'd1, 3);
        e = q5.pop_back();
        repeat (6) @(negedge clk);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({ifc5.in_ready, ifc5.out_valid, ifc5.out_class, ifc5.out_votes} !== {1'b1, 1'b0, 2'd0, 3'd0}) begin
            n_bad++;
            $display("FAIL abort_reset: rdy=%b vld=%b cls=%0d votes=%0d required 1 0 0 0 (dropped cls %0d)",
                     ifc5.in_ready, ifc5.out_valid, ifc5.out_class, ifc5.out_votes, e.cls);
        end
        @(negedge clk);
        rst = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (ifc5.out_valid !== 1'b0) pulses++;
        end
        n_cmp++;
        if (pulses != 0) begin
            n_bad++;
            $display("FAIL abort_no_strobe: got %0d pulses required 0", pulses);
        end
        send(5, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1},
             {2'd3,2'd3,2'd3,2'd0,2'd1,2'd2,2'd2,2'd3}, 2'd2, 2);
        wait_out(5, "after_abort");
    endtask

    task automatic test_k8();
        send(8, {16'd8,16'd7,16'd6,16'd5,16'd4,16'd3,16'd2,16'd1},
             {8{2'd2}}, 2'd2, 8);
        wait_out(8, "k8_all");
        send(8, {16'hFFFF,16'd7,16'd6,16'd5,16'hFFFF,16'd3,16'd2,16'd1},
             {2'd3,2'd3,2'd2,2'd2,2'd2,2'd1,2'd1,2'd0}, 2'd1, 2);
        wait_out(8, "k8_tie");
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_mid_argmax();
        test_k8();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
